// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings,
// parity-mode codes and counter sizing helper.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_SHIFT  = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // bits needed to hold the value v
  function automatic int clogb2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if (v >= (1 << i)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an async input
// with a registered-history falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic rx_s_d;

  // sync chain plus one-cycle history, all idle-high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      s1     <= rx;
      rx_s   <= s1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, mid-bit sampling,
// optional parity check and stop-bit check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD_RATE = 9600,
  parameter string PARITY    = "None",
  parameter int    FRAME_WD  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [FRAME_WD-1:0] dout,
  output logic                rx_valid,
  output logic                parity_err,
  output logic                frame_err,
  output logic                busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_DIV / 2;

  localparam logic [1:0] PMODE =
    (PARITY == "None") ? PAR_NONE :
    (PARITY == "Even") ? PAR_EVEN : PAR_ODD;
  localparam bit HAS_PAR = (PMODE != PAR_NONE);

  localparam int CW = clogb2(BAUD_DIV);
  localparam int BW = clogb2(FRAME_WD);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BITS_M1 = BW'(FRAME_WD - 1);

  uart_state_e         state;
  logic [CW-1:0]       baud_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [FRAME_WD-1:0] data_reg;
  logic                par_bad;
  logic                rx_s;
  logic                fall;
  logic                exp_par;
  logic                wrap;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign exp_par = (PMODE == PAR_EVEN) ? ^data_reg : ~^data_reg;
  assign wrap    = (baud_cnt == DIV_M1);
  assign busy    = (state != ST_IDLE);

  // frame FSM with baud/bit counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      data_reg   <= '0;
      par_bad    <= 1'b0;
      dout       <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            state    <= rx_s ? ST_IDLE : ST_SHIFT;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (wrap) begin
            baud_cnt <= '0;
            data_reg <= {rx_s, data_reg[FRAME_WD-1:1]};
            if (bit_cnt == BITS_M1) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (wrap) begin
            baud_cnt <= '0;
            par_bad  <= rx_s ^ exp_par;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (wrap) begin
            baud_cnt   <= '0;
            dout       <= data_reg;
            frame_err  <= ~rx_s;
            parity_err <= HAS_PAR ? par_bad : 1'b0;
            rx_valid   <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances
// (None/8, Even/8, Odd/5) at 16 clocks per bit.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  logic [7:0] dout_a, dout_b;
  logic [4:0] dout_c;
  logic v_a, v_b, v_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic busy_a, busy_b, busy_c;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1),
            .PARITY("None"), .FRAME_WD(8)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a),
    .dout(dout_a), .rx_valid(v_a),
    .parity_err(pe_a), .frame_err(fe_a),
    .busy(busy_a)
  );

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1),
            .PARITY("Even"), .FRAME_WD(8)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b),
    .dout(dout_b), .rx_valid(v_b),
    .parity_err(pe_b), .frame_err(fe_b),
    .busy(busy_b)
  );

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1),
            .PARITY("Odd"), .FRAME_WD(5)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c),
    .dout(dout_c), .rx_valid(v_c),
    .parity_err(pe_c), .frame_err(fe_c),
    .busy(busy_c)
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;

  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int pc_a = 0, pc_b = 0, pc_c = 0;
  logic busy_v_a = 1'b1;
  int pc_q[$];
  logic [7:0] d_q[$];

  // log every valid pulse, one count per high cycle
  always @(negedge clk) begin
    if (v_a) begin
      cnt_a++;
      pc_a = pcnt;
      busy_v_a = busy_a;
      pc_q.push_back(pcnt);
      d_q.push_back(dout_a);
    end
    if (v_b) begin
      cnt_b++;
      pc_b = pcnt;
    end
    if (v_c) begin
      cnt_c++;
      pc_c = pcnt;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int ln, input logic b);
    case (ln)
      0:       rx_a = b;
      1:       rx_b = b;
      default: rx_c = b;
    endcase
  endtask

  // v[0] goes first; each bit held 16 clocks
  task automatic send(input int ln,
                      input logic [15:0] v,
                      input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) t0 = pcnt;
      drive(ln, v[i]);
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0;
  int tt;

  initial begin
    idle(3);
    check("rst_dout", dout_a, 0);
    check("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_valid", cnt_a, 0);
    check("post_rst_flags", {pe_a, fe_a, busy_a}, 0);

    // 1: None, 0xA5
    c0 = cnt_a;
    send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    idle(20);
    check("t1_pulses", cnt_a - c0, 1);
    check("t1_latency", pc_a - t0 - 1, 154);
    check("t1_dout", dout_a, 8'hA5);
    check("t1_perr", pe_a, 0);
    check("t1_ferr", fe_a, 0);
    check("t1_busy_at_v", busy_v_a, 0);

    // 2: Even, 0x07 good then bad parity
    c0 = cnt_b;
    send(1, {5'h1f, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(20);
    check("t2a_pulses", cnt_b - c0, 1);
    check("t2a_dout", dout_b, 8'h07);
    check("t2a_perr", pe_b, 0);
    send(1, {5'h1f, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    idle(20);
    check("t2b_pulses", cnt_b - c0, 2);
    check("t2b_latency", pc_b - t0 - 1, 170);
    check("t2b_dout", dout_b, 8'h07);
    check("t2b_perr", pe_b, 1);

    // 3: 0x3C with stop low, line stays low
    c0 = cnt_a;
    send(0, {6'h00, 1'b0, 8'h3C, 1'b0}, 10);
    idle(40);
    rx_a = 1'b1;
    idle(200);
    check("t3_pulses", cnt_a - c0, 1);
    check("t3_dout", dout_a, 8'h3C);
    check("t3_ferr", fe_a, 1);

    // 4: 4-cycle glitch is a false start
    c0 = cnt_a;
    @(negedge clk);
    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(6);
    check("t4_busy_edge9", busy_a, 1);
    idle(1);
    check("t4_busy_edge10", busy_a, 0);
    idle(30);
    check("t4_pulses", cnt_a - c0, 0);
    check("t4_dout_hold", dout_a, 8'h3C);
    check("t4_ferr_hold", fe_a, 1);

    // 5: back-to-back 0x55, 0xAA, then reset mid-frame
    pc_q.delete();
    d_q.delete();
    c0 = cnt_a;
    send(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10);
    send(0, {6'h3f, 1'b1, 8'hAA, 1'b0}, 10);
    idle(20);
    check("t5_pulses", cnt_a - c0, 2);
    if (pc_q.size() == 2) begin
      check("t5_spacing", pc_q[1] - pc_q[0], 160);
      check("t5_d0", d_q[0], 8'h55);
      check("t5_d1", d_q[1], 8'hAA);
    end else begin
      check("t5_queue", pc_q.size(), 2);
    end
    check("t5_ferr_clr", fe_a, 0);
    c0 = cnt_a;
    send(0, {6'h3f, 1'b1, 8'h0F, 1'b0}, 4);
    check("t5_busy_mid", busy_a, 1);
    rst_n = 1'b0;
    idle(2);
    check("t5_rst_dout", dout_a, 0);
    check("t5_rst_flags", {v_a, pe_a, fe_a, busy_a}, 0);
    rx_a = 1'b1;
    rst_n = 1'b1;
    idle(250);
    check("t5_no_valid", cnt_a - c0, 0);
    check("t5_rst_busy", busy_a, 0);

    // 6: Odd, 5 bits, 5'h13 with parity 0
    c0 = cnt_c;
    send(2, {8'hff, 1'b1, 1'b0, 5'h13, 1'b0}, 8);
    idle(20);
    check("t6_pulses", cnt_c - c0, 1);
    check("t6_latency", pc_c - t0 - 1, 122);
    check("t6_dout", dout_c, 5'h13);
    check("t6_perr", pe_c, 0);
    check("t6_ferr", fe_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
